// File: rtl/gray_convert_arbiter.sv
// gray_convert_arbiter
// Shares one bit-serial Gray-to-binary XOR stage between NREQ requesters.
// A round-robin arbiter picks one requester while idle and captures its Gray
// word. The word is then decoded MSB-first, one bit per cycle, for WIDTH
// cycles. The binary result and the owner's index are then offered on a
// valid/ready port.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        one request bit per requester, held until granted
//   gray_in    packed Gray words, requester i at [i*WIDTH +: WIDTH]
//   grant      one-hot accept, combinational, only ever high while idle
//   bin_out    decoded binary word, qualified by out_valid
//   out_id     index of the requester that owns bin_out
//   out_valid  result available
//   out_ready  consumer accepts the result
//   busy       high whenever a conversion or handoff is in progress
module gray_convert_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int ID_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] gray_in,
  output logic [NREQ-1:0]       grant,
  output logic [WIDTH-1:0]      bin_out,
  output logic [ID_W-1:0]       out_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [ID_W-1:0]  last;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic             bit_next;
  logic [CNT_W-1:0] cnt;
  logic             found;
  logic [ID_W-1:0]  win;
  int               k;

  // Round-robin search starts just after the last winner and wraps, so the
  // most recently served requester has the lowest priority next time.
  always_comb begin
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      k = (int'(last) + i) % NREQ;
      if (!found && req[ID_W'(k)]) begin
        found = 1'b1;
        win   = ID_W'(k);
      end
    end
  end

  // Grant is only offered while idle; requests in other states wait.
  always_comb begin
    grant = '0;
    if (state == IDLE && found) grant[win] = 1'b1;
  end

  // The single shared XOR stage: current Gray bit against the previous binary
  // bit. The carry is cleared at capture, which stands in for b[WIDTH] = 0.
  always_comb begin
    bit_next      = shreg[cnt] ^ carry;
    acc_next      = acc;
    acc_next[cnt] = bit_next;
  end

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Main sequencer. bin_out is written only on the final shift cycle, so it
  // keeps the previous result until the next conversion completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= ID_W'(NREQ - 1);
      shreg   <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      bin_out <= '0;
      out_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            shreg  <= gray_in[int'(win)*WIDTH +: WIDTH];
            out_id <= win;
            last   <= win;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= CNT_W'(WIDTH - 1);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= acc_next;
          carry <= bit_next;
          if (cnt == '0) begin
            bin_out <= acc_next;
            state   <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_convert_arbiter.sv
// tb_gray_convert_arbiter
// Self-checking bench for gray_convert_arbiter. It drives requesters,
// reset and consumer backpressure. A transaction-level reference model
// predicts grant, busy, out_valid, out_id and bin_out every cycle.
module tb_gray_convert_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  localparam int M_SINGLE   = 0;
  localparam int M_ALL      = 1;
  localparam int M_BACKPRES = 2;
  localparam int M_RESET    = 3;
  localparam int M_EXHAUST  = 4;
  localparam int M_FAIR     = 5;
  localparam int M_RANDOM   = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] gray_in;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      bin_out;
  logic [ID_W-1:0]       out_id;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;

  int checks = 0;
  int passes = 0;

  // Requester-side view: who is currently holding a request, with which word.
  bit               holding [NREQ];
  logic [WIDTH-1:0] word    [NREQ];
  int               launched;
  int               nextCode;
  bit               resetDone;

  // Reference model: last winner, conversion cycles still to run, and the
  // result waiting for the consumer.
  int               lastWin;
  int               shiftLeft;
  bit               resultPending;
  int               curId;
  logic [WIDTH-1:0] pendingBin;
  logic [WIDTH-1:0] lastBin;

  gray_convert_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gray_in   (gray_in),
    .grant     (grant),
    .bin_out   (bin_out),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Binary from Gray: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] grayToBin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    for (int s = 0; s < WIDTH; s++) b ^= g >> s;
    return b;
  endfunction

  // Next winner: first holding requester after the last one served, wrapping.
  function automatic int pickWinner();
    for (int i = 1; i <= NREQ; i++) begin
      if (holding[(lastWin + i) % NREQ]) return (lastWin + i) % NREQ;
    end
    return -1;
  endfunction

  // Model reset state mirrors what the block looks like right after reset.
  task automatic resetModel();
    lastWin       = NREQ - 1;
    shiftLeft     = 0;
    resultPending = 1'b0;
    curId         = 0;
    pendingBin    = '0;
    lastBin       = '0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model
  // across the coming rising edge.
  task automatic modelEdge();
    bit idle;
    int w;
    idle = (shiftLeft == 0) && !resultPending;
    w    = idle ? pickWinner() : -1;
    if (!rst) checkOutput("grant", grant, (w >= 0) ? (64'd1 << w) : 64'd0);
    checkOutput("busy", busy, !idle);
    checkOutput("out_valid", out_valid, resultPending);
    checkOutput("out_id", out_id, curId);
    checkOutput("bin_out", bin_out, lastBin);
    if (rst) begin
      resetModel();
    end else if (w >= 0) begin
      holding[w] = 1'b0;
      lastWin    = w;
      curId      = w;
      pendingBin = grayToBin(word[w]);
      shiftLeft  = WIDTH;
    end else if (shiftLeft > 0) begin
      shiftLeft--;
      if (shiftLeft == 0) begin
        resultPending = 1'b1;
        lastBin       = pendingBin;
      end
    end else if (resultPending && out_ready) begin
      resultPending = 1'b0;
    end
  endtask

  task automatic raise(input int idx, input logic [WIDTH-1:0] value);
    holding[idx] = 1'b1;
    word[idx]    = value;
    launched++;
  endtask

  // Drive the next cycle's inputs according to the scenario being run.
  task automatic applyStimulus(input int mode);
    rst       = 1'b0;
    out_ready = 1'b1;
    case (mode)
      M_SINGLE: if (launched == 0) raise(0, 4'b1011);
      M_ALL: if (launched == 0) begin
        raise(0, 4'b0000);
        raise(1, 4'b0001);
        raise(2, 4'b0011);
        raise(3, 4'b0010);
      end
      M_BACKPRES: begin
        if (!holding[1]) raise(1, WIDTH'($urandom));
        out_ready = ($urandom_range(0, 5) == 0);
      end
      M_RESET: begin
        if (!resetDone) begin
          if (launched == 0) raise(1, WIDTH'($urandom));
          else if (shiftLeft == WIDTH - 1) begin
            rst       = 1'b1;
            resetDone = 1'b1;
          end
        end else if (launched == 1) begin
          raise(0, WIDTH'($urandom));
          raise(2, WIDTH'($urandom));
        end
      end
      M_EXHAUST: if (!holding[2] && nextCode < 16) begin
        raise(2, WIDTH'(nextCode));
        nextCode++;
      end
      M_FAIR: begin
        if (!holding[0]) raise(0, WIDTH'($urandom));
        if (!holding[3]) raise(3, WIDTH'($urandom));
      end
      default: begin
        for (int i = 0; i < NREQ; i++) begin
          if (!holding[i] && $urandom_range(0, 2) == 0) raise(i, WIDTH'($urandom));
          else if (holding[i] && $urandom_range(0, 29) == 0) holding[i] = 1'b0;
          else if (!holding[i]) word[i] = WIDTH'($urandom);
        end
        out_ready = $urandom_range(0, 1) == 1;
        rst       = ($urandom_range(0, 299) == 0);
      end
    endcase
    for (int i = 0; i < NREQ; i++) begin
      req[i]                     = holding[i];
      gray_in[i*WIDTH +: WIDTH] = word[i];
    end
  endtask

  // Each scenario starts from a one-cycle reset with every request dropped.
  task automatic runMode(input int mode, input int cycles);
    for (int i = 0; i < NREQ; i++) begin
      holding[i] = 1'b0;
      req[i]     = 1'b0;
    end
    launched  = 0;
    nextCode  = 0;
    resetDone = 1'b0;
    rst       = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      modelEdge();
      @(posedge clk);
      #1;
      applyStimulus(mode);
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) word[i] = '0;
    req       = '0;
    gray_in   = '0;
    out_ready = 1'b1;
    rst       = 1'b1;
    resetModel();
    @(posedge clk);
    #1;
    runMode(M_SINGLE, 20);
    runMode(M_ALL, 40);
    runMode(M_BACKPRES, 80);
    runMode(M_RESET, 40);
    runMode(M_EXHAUST, 110);
    runMode(M_FAIR, 60);
    runMode(M_RANDOM, 2000);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gray_convert_arbiter.md
Name: gray_convert_arbiter

Overview:
- Shares one bit-serial Gray-to-binary XOR stage among NREQ requesters.
- A round-robin arbiter grants one requester and captures its Gray word.
- An FSM sequences the XOR chain MSB-first over WIDTH cycles.
- The binary result and requester ID are presented on a valid/ready output port.
- Sits between requesting blocks and any consumer of binary-decoded Gray values, e.g. position counters.

Parameters:
- WIDTH, 4, Gray/binary word width; must be ≥1.
- NREQ, 4, number of requesters; must be ≥2.
- ID_W, $clog2(NREQ), width of out_id; derived, not overridden.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request per requester; held until granted.
- gray_in  input  NREQ*WIDTH  Gray words; requester i occupies bits [i*WIDTH +: WIDTH]; held stable with req.
- grant  output  NREQ  one-hot accept, combinational, high only in IDLE.
- bin_out  output  WIDTH  converted binary word; valid when out_valid.
- out_id  output  ID_W  index of the requester that owns bin_out.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset values (effective the cycle after rst is sampled high):
  - state=IDLE; grant=0; out_valid=0; bin_out=0; out_id=0; busy=0.
  - Shift/accumulator registers are 0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority after reset.
- rst overrides everything, including mid-SHIFT or DONE. A partial or unaccepted result is discarded and no out_valid is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - grant = one-hot of the first asserted req, searching indices last+1, last+2, … mod NREQ.
  - grant=0 if no req is asserted.
  - At the edge where grant≠0: capture the granted gray_in into the shift register, set out_id=index, set last=index, clear the accumulator, load cnt=WIDTH-1, and go to SHIFT.
  - The requester treats (req & grant) sampled at an edge as the accept. It may drop req or change gray_in from the next cycle.
- SHIFT, one bit per cycle, k = cnt, MSB first:
  - b[k] = g[k] XOR b[k+1], with b[WIDTH] treated as 0.
  - Uses a single XOR stage plus a 1-bit carry register holding the previous b.
  - cnt decrements each cycle. At the edge with cnt=0, go to DONE.
  - Exactly WIDTH cycles in SHIFT. WIDTH=1 gives one cycle and bin=gray.
- DONE:
  - out_valid=1; bin_out and out_id are held stable.
  - grant=0 regardless of req.
  - At an edge with out_valid & out_ready, go to IDLE.
  - out_ready is ignored in every other state.
- Latency: out_valid rises WIDTH cycles after the accept edge. Minimum spacing between grants is WIDTH+2 cycles, with out_ready held high.
- req from a non-granted requester has no effect. If it is dropped before grant, nothing is recorded.
- Requests that arrive during SHIFT/DONE are arbitrated in the next IDLE cycle; no request is lost while held.
- Fairness: a continuously asserted requester waits at most NREQ-1 conversions.
- bin_out retains its last value after the handshake until the next DONE; out_valid qualifies it.

Test Plan:
1. Reset, then req=4'b0001, gray_in[3:0]=4'b1011 -> grant=4'b0001 the same cycle; busy=1 next cycle; out_valid rises 4 cycles after accept with bin_out=4'b1101, out_id=0. With out_ready=1, return to IDLE.
2. All four req high, gray words 0000/0001/0011/0010 for requesters 0..3, out_ready=1 -> grants in order 0,1,2,3; outputs (id,bin) = (0,0000), (1,0001), (2,0010), (3,0011); spacing 6 cycles.
3. Backpressure: hold out_ready=0 for 5 cycles in DONE with req1 high -> out_valid, bin_out and out_id stable; grant=0; busy=1. Then out_ready=1 -> IDLE next cycle, then req1 granted.
4. Assert rst during the 2nd SHIFT cycle -> next cycle state IDLE with all outputs 0, no out_valid ever produced. Then with req0 and req2 both high, requester 0 is granted first.
5. Exhaustive: all 16 Gray codes on requester 2 -> bin_out equals the reference conversion (b[i] = XOR of g[3:i]) for every code; out_id=2 each time.
6. Fairness: req0 and req3 held high continuously -> grant sequence 0,3,0,3,… with no starvation over 8 conversions.
